// File: rtl/timer_arb_pkg.sv
// Shared types and helpers for the interval timer arbiter.
package timer_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Index width for n requesters, never below one bit.
  function automatic int unsigned id_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick: first set request at or above ptr, wrapping; purely combinational.
module rr_arbiter
  import timer_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] onehot_c,
  output logic [ID_W-1:0]    idx_c,
  output logic               valid_c
);

  int unsigned cand;

  // Scan offsets from farthest to nearest so the nearest set bit wins.
  always_comb begin
    onehot_c = '0;
    idx_c    = '0;
    valid_c  = 1'b0;
    cand     = 0;
    for (int i = int'(NUM_REQ) - 1; i >= 0; i--) begin
      cand = (32'(ptr) + unsigned'(i)) % NUM_REQ;
      if (req[cand]) begin
        valid_c = 1'b1;
        idx_c   = ID_W'(cand);
      end
    end
    if (valid_c) onehot_c[idx_c] = 1'b1;
  end

endmodule

// File: rtl/interval_timer_arbiter.sv
// Shared interval counter granted round-robin among requesters.
module interval_timer_arbiter
  import timer_arb_pkg::*;
#(
  parameter  int unsigned NUM_REQ   = 4,
  parameter  int unsigned CNT_W     = 5,
  parameter  int unsigned MAX_VALUE = 25,
  localparam int unsigned ID_W      = id_width(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*CNT_W-1:0] len,
  output logic [NUM_REQ-1:0]       grant,
  output logic                     busy,
  output logic [CNT_W-1:0]         count,
  output logic                     done,
  output logic [ID_W-1:0]          done_id
);

  localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_VALUE);

  state_t             state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d, win_onehot;
  logic [ID_W-1:0]    win_idx, owner_q, owner_d, ptr_q, ptr_d, done_id_q, done_id_d;
  logic               win_valid;
  logic [CNT_W-1:0]   count_q, count_d, len_q, len_d, len_sel;
  logic               done_q, done_d, busy_q;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_arb (
    .req      (req),
    .ptr      (ptr_q),
    .onehot_c (win_onehot),
    .idx_c    (win_idx),
    .valid_c  (win_valid)
  );

  // Next-state and next-output logic.
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    count_d   = count_q;
    len_d     = len_q;
    owner_d   = owner_q;
    ptr_d     = ptr_q;
    done_d    = 1'b0;
    done_id_d = '0;
    len_sel   = len[int'(win_idx)*int'(CNT_W) +: CNT_W];
    case (state_q)
      ST_IDLE: begin
        grant_d = '0;
        count_d = '0;
        if (win_valid) begin
          state_d = ST_RUN;
          grant_d = win_onehot;
          owner_d = win_idx;
          len_d   = (len_sel > MAX_C) ? MAX_C : len_sel;
          ptr_d   = (32'(win_idx) == NUM_REQ - 1) ? '0 : win_idx + ID_W'(1);
        end
      end
      ST_RUN: begin
        if (!req[owner_q]) begin
          // Owner withdrew: drop the interval silently.
          state_d = ST_IDLE;
          grant_d = '0;
          count_d = '0;
        end else if (count_q == len_q) begin
          state_d   = ST_DONE;
          done_d    = 1'b1;
          done_id_d = owner_q;
        end else begin
          count_d = count_q + CNT_W'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        grant_d = '0;
        count_d = '0;
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
        count_d = '0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      grant_q   <= '0;
      count_q   <= '0;
      len_q     <= '0;
      owner_q   <= '0;
      ptr_q     <= '0;
      done_q    <= 1'b0;
      done_id_q <= '0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      count_q   <= count_d;
      len_q     <= len_d;
      owner_q   <= owner_d;
      ptr_q     <= ptr_d;
      done_q    <= done_d;
      done_id_q <= done_id_d;
      busy_q    <= (state_d != ST_IDLE);
    end
  end

  assign grant   = grant_q;
  assign busy    = busy_q;
  assign count   = count_q;
  assign done    = done_q;
  assign done_id = done_id_q;

endmodule

// File: tb/tb_interval_timer_arbiter.sv
// Directed bench for interval_timer_arbiter: vector table plus corner-case sequences.
module tb_interval_timer_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [19:0] len;
  logic [3:0]  grant;
  logic        busy;
  logic [4:0]  count;
  logic        done;
  logic [1:0]  done_id;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [3:0]  req;
    logic [19:0] len;
    logic [3:0]  g;
    logic        b;
    logic [4:0]  c;
    logic        d;
    logic [1:0]  id;
  } vec_t;

  vec_t tbl[14];

  interval_timer_arbiter #(.NUM_REQ(4), .CNT_W(5), .MAX_VALUE(25)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .len     (len),
    .grant   (grant),
    .busy    (busy),
    .count   (count),
    .done    (done),
    .done_id (done_id)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic [3:0] r, input logic [19:0] l, input logic [3:0] g,
                              input logic b, input logic [4:0] c, input logic d,
                              input logic [1:0] id);
    vec_t v;
    v.req = r; v.len = l; v.g = g; v.b = b; v.c = c; v.d = d; v.id = id;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_all(input string tag, input logic [3:0] g, input logic b,
                         input logic [4:0] c, input logic d, input logic [1:0] id);
    chk({tag, ".grant"}, 32'(grant), 32'(g));
    chk({tag, ".busy"},  32'(busy),  32'(b));
    chk({tag, ".count"}, 32'(count), 32'(c));
    chk({tag, ".done"},  32'(done),  32'(d));
    if (d) chk({tag, ".done_id"}, 32'(done_id), 32'(id));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Single interval len1=3, then len2 changed mid-run from 4 to 1.
    tbl[0]  = mk(4'b0010, 20'h00060, 4'b0010, 1'b1, 5'd0, 1'b0, 2'd0);
    tbl[1]  = mk(4'b0010, 20'h00060, 4'b0010, 1'b1, 5'd1, 1'b0, 2'd0);
    tbl[2]  = mk(4'b0010, 20'h00060, 4'b0010, 1'b1, 5'd2, 1'b0, 2'd0);
    tbl[3]  = mk(4'b0010, 20'h00060, 4'b0010, 1'b1, 5'd3, 1'b0, 2'd0);
    tbl[4]  = mk(4'b0010, 20'h00060, 4'b0010, 1'b1, 5'd3, 1'b1, 2'd1);
    tbl[5]  = mk(4'b0000, 20'h00000, 4'b0000, 1'b0, 5'd0, 1'b0, 2'd0);
    tbl[6]  = mk(4'b0000, 20'h00000, 4'b0000, 1'b0, 5'd0, 1'b0, 2'd0);
    tbl[7]  = mk(4'b0100, 20'h01000, 4'b0100, 1'b1, 5'd0, 1'b0, 2'd0);
    tbl[8]  = mk(4'b0100, 20'h00400, 4'b0100, 1'b1, 5'd1, 1'b0, 2'd0);
    tbl[9]  = mk(4'b0100, 20'h00400, 4'b0100, 1'b1, 5'd2, 1'b0, 2'd0);
    tbl[10] = mk(4'b0100, 20'h00400, 4'b0100, 1'b1, 5'd3, 1'b0, 2'd0);
    tbl[11] = mk(4'b0100, 20'h00400, 4'b0100, 1'b1, 5'd4, 1'b0, 2'd0);
    tbl[12] = mk(4'b0100, 20'h00400, 4'b0100, 1'b1, 5'd4, 1'b1, 2'd2);
    tbl[13] = mk(4'b0000, 20'h00000, 4'b0000, 1'b0, 5'd0, 1'b0, 2'd0);

    rst = 1'b1; req = '0; len = '0;
    step();
    chk("reset.done_id", 32'(done_id), 32'd0);
    chk_all("reset", 4'b0000, 1'b0, 5'd0, 1'b0, 2'd0);
    rst = 1'b0;

    for (int i = 0; i < 14; i++) begin
      req = tbl[i].req;
      len = tbl[i].len;
      step();
      chk_all($sformatf("vec%0d", i), tbl[i].g, tbl[i].b, tbl[i].c, tbl[i].d, tbl[i].id);
    end

    // All four requesting with len=0: rotation 0,1,2,3,0 from pointer 0.
    rst = 1'b1; step(); rst = 1'b0;
    req = 4'b1111; len = '0;
    step();
    chk_all("rr.grant0", 4'b0001, 1'b1, 5'd0, 1'b0, 2'd0);
    for (int k = 0; k < 5; k++) begin
      int e;
      e = k % 4;
      step();
      chk_all($sformatf("rr.done%0d", k), 4'(1 << e), 1'b1, 5'd0, 1'b1, 2'(e));
      req[e] = 1'b0;
      step();
      chk_all($sformatf("rr.idle%0d", k), 4'b0000, 1'b0, 5'd0, 1'b0, 2'd0);
      if (k < 4) begin
        step();
        chk_all($sformatf("rr.grant%0d", k + 1), 4'(1 << ((k + 1) % 4)), 1'b1, 5'd0, 1'b0, 2'd0);
        req[e] = 1'b1;
      end
    end
    req = '0;
    step();
    chk_all("rr.quiet", 4'b0000, 1'b0, 5'd0, 1'b0, 2'd0);

    // len2=31 clamps to 25: 26 RUN cycles, count never above 25.
    req = 4'b0100; len = 20'(31) << 10;
    for (int c = 0; c <= 25; c++) begin
      step();
      chk_all($sformatf("clamp.c%0d", c), 4'b0100, 1'b1, 5'(c), 1'b0, 2'd0);
    end
    step();
    chk_all("clamp.done", 4'b0100, 1'b1, 5'd25, 1'b1, 2'd2);
    req = '0;
    step();
    chk_all("clamp.idle", 4'b0000, 1'b0, 5'd0, 1'b0, 2'd0);

    // Reset at count=10 discards the interval and resets the pointer.
    req = 4'b0100; len = 20'(15) << 10;
    for (int c = 0; c <= 10; c++) begin
      step();
      chk($sformatf("rstrun.c%0d", c), 32'(count), 32'(c));
    end
    rst = 1'b1;
    step();
    chk_all("rstrun.reset", 4'b0000, 1'b0, 5'd0, 1'b0, 2'd0);
    rst = 1'b0; req = 4'b0110;
    step();
    chk_all("rstrun.grant", 4'b0010, 1'b1, 5'd0, 1'b0, 2'd0);

    // Abort: req[0] dropped at count=2, pending req[3] wins next.
    req = '0;
    rst = 1'b1; step(); rst = 1'b0;
    req = 4'b1001; len = 20'd5;
    for (int c = 0; c <= 2; c++) begin
      step();
      chk_all($sformatf("abort.c%0d", c), 4'b0001, 1'b1, 5'(c), 1'b0, 2'd0);
    end
    req = 4'b1000;
    step();
    chk_all("abort.idle", 4'b0000, 1'b0, 5'd0, 1'b0, 2'd0);
    step();
    chk_all("abort.grant3", 4'b1000, 1'b1, 5'd0, 1'b0, 2'd0);
    req = '0;
    step();
    chk_all("abort.end", 4'b0000, 1'b0, 5'd0, 1'b0, 2'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
